// File: rtl/game_tick_divider.sv
// Programmable game timebase: one-cycle Enable strobe every P clocks with
// start/pause/resume, one-shot or periodic mode, deferred period reload and
// a wrapping tick counter. Optional auto-speedup ramp: DIV_AUTOSPEED_EN.
//
// Ports:
//   ClockIn, Reset      clock, synchronous active-high reset
//   Start, Stop         start/resume and pause requests
//   OneShot             mode, latched when leaving IDLE/DONE
//   PeriodIn/PeriodLoad period write (0 is stored as 1)
//   Enable              registered one-cycle tick strobe
//   Busy, Done          RUN/PAUSE and DONE state flags
//   TickCount           strobes since last start, wraps
module game_tick_divider #(
    parameter int WIDTH          = 27,
    parameter int DEFAULT_PERIOD = 50000000,
    parameter int CNT_WIDTH      = 8,
    parameter int MIN_PERIOD     = 5000000,
    parameter int SPEEDUP_LOG2   = 3
) (
    input  logic                 ClockIn,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 OneShot,
    input  logic [WIDTH-1:0]     PeriodIn,
    input  logic                 PeriodLoad,
    output logic                 Enable,
    output logic                 Busy,
    output logic                 Done,
    output logic [CNT_WIDTH-1:0] TickCount
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_R = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DEF_P = (DEF_R == '0) ? ONE : DEF_R;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     period_q, period_d;
    logic [WIDTH-1:0]     pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 oneshot_q, oneshot_d;
    logic                 en_q, en_d;
    logic                 busy_q, done_q;
    logic [CNT_WIDTH-1:0] tick_q, tick_d;

    logic [WIDTH-1:0]     load_val;
    logic [WIDTH-1:0]     commit_p;
    logic [WIDTH-1:0]     reload_p;
    logic [CNT_WIDTH-1:0] tick_inc;

    // A zero period would never strobe; clamp it to one.
    assign load_val = (PeriodIn == '0) ? ONE : PeriodIn;
    assign tick_inc = tick_q + CNT_WIDTH'(1);

    // Value taking effect at a reload: a same-edge write beats an
    // older pending write, which beats the current period.
    assign commit_p = PeriodLoad ? load_val :
                      (pend_vld_q ? pend_q : period_q);

`ifdef DIV_AUTOSPEED_EN
    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

    logic [WIDTH-1:0] shrunk;
    logic [WIDTH-1:0] speed_p;
    logic             speed_hit;

    assign shrunk  = period_q - (period_q >> 4);
    assign speed_p = (shrunk < MIN_P) ? MIN_P : shrunk;

    // Explicit period writes take precedence over the ramp.
    assign speed_hit = !oneshot_q && !PeriodLoad && !pend_vld_q &&
                       (tick_inc[SPEEDUP_LOG2-1:0] == '0);

    assign reload_p = speed_hit ? speed_p : commit_p;
`else
    logic unused_params;
    assign unused_params = (MIN_PERIOD == SPEEDUP_LOG2);
    assign reload_p = commit_p;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        oneshot_d  = oneshot_q;
        tick_d     = tick_q;
        en_d       = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (PeriodLoad) begin
                    period_d = load_val;
                end
                if (Start && !Stop) begin
                    cnt_d     = (PeriodLoad ? load_val : period_q) - ONE;
                    oneshot_d = OneShot;
                    tick_d    = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (PeriodLoad) begin
                    pend_d     = load_val;
                    pend_vld_d = 1'b1;
                end
                if (Stop) begin
                    // Stop wins over a strobe due on this edge.
                    state_d = S_PAUSE;
                end else if (cnt_q == '0) begin
                    en_d       = 1'b1;
                    tick_d     = tick_inc;
                    period_d   = reload_p;
                    pend_vld_d = 1'b0;
                    if (oneshot_q) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = reload_p - ONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_PAUSE: begin
                if (PeriodLoad) begin
                    pend_d     = load_val;
                    pend_vld_d = 1'b1;
                end
                if (Start && !Stop) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= DEF_P;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            oneshot_q  <= 1'b0;
            tick_q     <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            oneshot_q  <= oneshot_d;
            tick_q     <= tick_d;
            en_q       <= en_d;
            busy_q     <= (state_d == S_RUN) || (state_d == S_PAUSE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign Enable    = en_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign TickCount = tick_q;

endmodule

// File: tb/tb_game_tick_divider.sv
// Scoreboard bench for game_tick_divider: stimulus queues expected strobe
// edges and tick values, a negedge monitor pops them on every Enable.
module tb_game_tick_divider;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          oneshot = 1'b0;
    logic          pload = 1'b0;
    logic [W-1:0]  pin = '0;
    logic          en;
    logic          busy;
    logic          done;
    logic [CW-1:0] tc;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int en_edge;
        int tick;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    game_tick_divider #(
        .WIDTH(W),
        .DEFAULT_PERIOD(7),
        .CNT_WIDTH(CW),
        .MIN_PERIOD(12),
        .SPEEDUP_LOG2(1)
    ) dut (
        .ClockIn(clk),
        .Reset(rst),
        .Start(start),
        .Stop(stop),
        .OneShot(oneshot),
        .PeriodIn(pin),
        .PeriodLoad(pload),
        .Enable(en),
        .Busy(busy),
        .Done(done),
        .TickCount(tc)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int e, input int t);
        exp_t x;
        x.en_edge = e;
        x.tick = t % 4;
        q.push_back(x);
    endtask

    // Returns at the negedge before edge e; inputs set now apply at e.
    task automatic upto(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_enable", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", tc, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (q.size() > 0 && q[0].en_edge < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_strobe: none at edge %0d expected %0d",
                     cyc - 1, q[0].en_edge);
            void'(q.pop_front());
        end
        if (en) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: at edge %0d expected none",
                         cyc);
            end else begin
                x = q.pop_front();
                chk("strobe_edge", cyc, x.en_edge);
                chk("strobe_tick", tc, x.tick);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

`ifdef DIV_AUTOSPEED_EN
    initial begin
        int p;
        int e;
        int t;
        upto(3);
        rst = 1'b0;
        chk_reset_state();
        pload = 1'b1;
        pin = 8'd32;
        upto(4);
        pload = 1'b0;
        start = 1'b1;
        oneshot = 1'b0;
        p = 32;
        e = 4;
        t = 0;
        for (int k = 0; k < 12; k++) begin
            e = e + p;
            t = t + 1;
            push(e, t);
            if (t % 2 == 0) begin
                p = p - (p >> 4);
                if (p < 12) p = 12;
            end
        end
        upto(5);
        start = 1'b0;
        chk("as_busy", busy, 1);
        upto(e + 2);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
`else
    initial begin
        int b;
        int c;
        int d;
        int f;
        upto(3);
        rst = 1'b0;
        chk_reset_state();

        b = 3;
        start = 1'b1;
        oneshot = 1'b1;
        push(b + 7, 1);
        upto(b + 1);
        start = 1'b0;
        chk("os_busy", busy, 1);
        chk("os_done", done, 0);
        upto(b + 8);
        chk("os_done_hi", done, 1);
        chk("os_busy_lo", busy, 0);
        upto(b + 28);
        chk("os_done_hold", done, 1);

        c = b + 28;
        pload = 1'b1;
        pin = 8'd4;
        upto(c + 1);
        pload = 1'b0;
        start = 1'b1;
        push(c + 5, 1);
        upto(c + 2);
        start = 1'b0;
        upto(c + 6);
        chk("os4_done", done, 1);

        d = c + 8;
        upto(d);
        start = 1'b1;
        oneshot = 1'b0;
        for (int k = 1; k <= 5; k++) push(d + 4 * k, k);
        upto(d + 1);
        start = 1'b0;
        chk("per_busy", busy, 1);
        chk("per_done", done, 0);
        upto(d + 6);
        start = 1'b1;
        upto(d + 7);
        start = 1'b0;
        upto(d + 13);
        chk("per_tick3", tc, 3);

        upto(d + 24);
        stop = 1'b1;
        upto(d + 25);
        chk("stop_suppress_tick", tc, 1);
        chk("pause_busy", busy, 1);
        upto(d + 29);
        start = 1'b1;
        upto(d + 30);
        chk("startstop_busy", busy, 1);
        stop = 1'b0;
        push(d + 31, 2);
        push(d + 35, 3);
        upto(d + 31);
        start = 1'b0;

        upto(d + 32);
        pload = 1'b1;
        pin = 8'd6;
        push(d + 41, 0);
        upto(d + 33);
        pload = 1'b0;

        upto(d + 43);
        stop = 1'b1;
        upto(d + 48);
        stop = 1'b0;
        start = 1'b1;
        push(d + 53, 1);
        upto(d + 49);
        start = 1'b0;

        upto(d + 54);
        pload = 1'b1;
        pin = 8'd0;
        upto(d + 55);
        pload = 1'b0;
        push(d + 59, 2);
        push(d + 60, 3);
        push(d + 61, 0);
        push(d + 62, 1);

        upto(d + 63);
        rst = 1'b1;
        upto(d + 64);
        chk_reset_state();
        rst = 1'b0;

        f = d + 64;
        start = 1'b1;
        push(f + 7, 1);
        push(f + 14, 2);
        upto(f + 1);
        start = 1'b0;
        upto(f + 16);
        rst = 1'b1;
        upto(f + 18);
        rst = 1'b0;
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
`endif

endmodule
